// File: rtl/sensor_alarm_ctrl.sv
// sensor_alarm_ctrl: debounced N-channel sensor decoder with a latching,
// acknowledgeable blinking alarm lamp.
module sensor_alarm_ctrl #(
    parameter int N         = 3,
    parameter int DEBOUNCE  = 4,
    parameter int WARN_TH   = 2,
    parameter int BLINK_DIV = 8
) (
    input  logic         CLK,
    input  logic         RST_N,
    input  logic [N-1:0] S,
    input  logic         ACK,
    output logic         G,
    output logic         Y,
    output logic         C,
    output logic         D,
    output logic         R
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int KW = $clog2(N + 1);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE - 1);
    localparam logic [BW-1:0] BLK_MAX = BW'(BLINK_DIV - 1);
    localparam logic [KW-1:0] K_WARN  = KW'(WARN_TH);
    localparam logic [KW-1:0] K_ALL   = KW'(N);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ALARM = 2'd1,
        HOLD  = 2'd2,
        ACKED = 2'd3
    } state_t;

    logic [N-1:0]         deb_q, deb_d;
    logic [N-1:0][CW-1:0] cnt_q, cnt_d;
    logic [KW-1:0]        k;
    logic                 all_on;
    state_t               state_q, state_d;
    logic [BW-1:0]        bcnt_q, bcnt_d;
    logic                 phase_q, phase_d;

    // Debounce next state: a channel flips only after DEBOUNCE disagreeing cycles
    always_comb begin
        deb_d = deb_q;
        cnt_d = '0;
        for (int i = 0; i < N; i++) begin
            if (S[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = S[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end

    // Debounce registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            deb_q <= '0;
            cnt_q <= '0;
        end else begin
            deb_q <= deb_d;
            cnt_q <= cnt_d;
        end
    end

    // Indicator decode from registered debounced vector only
    always_comb begin
        k = '0;
        for (int i = 0; i < N; i++) begin
            k = k + KW'(deb_q[i]);
        end
        G      = (k != '0);
        Y      = (k >= K_WARN);
        C      = (k < K_ALL);
        D      = ~^deb_q;
        all_on = ~C;
    end

    // Alarm state register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Alarm next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (all_on) state_d = ALARM;
            end
            ALARM: begin
                if (all_on && ACK) begin
                    state_d = ACKED;
                end else if (!all_on) begin
                    state_d = ACK ? IDLE : HOLD;
                end
            end
            HOLD: begin
                if (all_on) begin
                    state_d = ALARM;
                end else if (ACK) begin
                    state_d = IDLE;
                end
            end
            ACKED: begin
                if (!all_on) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Lamp output per state
    always_comb begin
        R = 1'b1;
        unique case (state_q)
            IDLE:    R = D;
            ALARM:   R = phase_q;
            HOLD:    R = 1'b1;
            ACKED:   R = 1'b1;
            default: R = 1'b1;
        endcase
    end

    // Blink divider next state: restart high on ALARM entry, count in ALARM
    always_comb begin
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
        if (state_d == ALARM && state_q != ALARM) begin
            bcnt_d  = '0;
            phase_d = 1'b1;
        end else if (state_q == ALARM) begin
            if (bcnt_q == BLK_MAX) begin
                bcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                bcnt_d = bcnt_q + BW'(1);
            end
        end
    end

    // Blink divider registers
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bcnt_q  <= '0;
            phase_q <= 1'b0;
        end else begin
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
        end
    end

endmodule

// File: tb/tb_sensor_alarm_ctrl.sv
// tb_sensor_alarm_ctrl: directed table, corner sequences and randomized
// stimulus against a behavioural model of sensor_alarm_ctrl.
module tb_sensor_alarm_ctrl;

    localparam int N   = 3;
    localparam int DEB = 4;
    localparam int WTH = 2;
    localparam int BDV = 8;

    logic         CLK;
    logic         RST_N;
    logic [N-1:0] S;
    logic         ACK;
    logic         G, Y, C, D, R;

    int vectors;
    int miscompares;

    sensor_alarm_ctrl #(
        .N(N), .DEBOUNCE(DEB), .WARN_TH(WTH), .BLINK_DIV(BDV)
    ) dut (
        .CLK(CLK), .RST_N(RST_N), .S(S), .ACK(ACK),
        .G(G), .Y(Y), .C(C), .D(D), .R(R)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // expected output order: {G, Y, C, D, R}
    typedef struct {
        logic [N-1:0] s;
        logic         ack;
        logic [4:0]   exp;
    } vec_t;

    vec_t tbl[$];

    // behavioural model
    typedef enum {M_IDLE, M_ALARM, M_HOLD, M_ACKED} mst_t;
    logic [N-1:0] m_deb;
    int           m_run[N];
    mst_t         m_st;
    int           m_t;
    bit           model_on;

    task automatic model_reset();
        m_deb = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        m_st = M_IDLE;
        m_t  = 0;
    endtask

    task automatic model_step(input logic [N-1:0] s, input logic a);
        bit   full;
        mst_t nx;
        full = ($countones(m_deb) == N);
        nx   = m_st;
        case (m_st)
            M_IDLE:  if (full) nx = M_ALARM;
            M_ALARM: if (full && a) nx = M_ACKED;
                     else if (!full) nx = a ? M_IDLE : M_HOLD;
            M_HOLD:  if (full) nx = M_ALARM;
                     else if (a) nx = M_IDLE;
            M_ACKED: if (!full) nx = M_IDLE;
            default: nx = M_IDLE;
        endcase
        if (nx == M_ALARM && m_st != M_ALARM) m_t = 0;
        else if (m_st == M_ALARM) m_t++;
        m_st = nx;
        for (int i = 0; i < N; i++) begin
            if (s[i] != m_deb[i]) begin
                m_run[i]++;
                if (m_run[i] == DEB) begin
                    m_deb[i] = s[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
    endtask

    function automatic logic [4:0] model_exp();
        int   k;
        logic g, y, c, d, r;
        k = $countones(m_deb);
        g = (k >= 1);
        y = (k >= WTH);
        c = (k < N);
        d = (k % 2 == 0);
        if (m_st == M_ALARM) r = ((m_t / BDV) % 2 == 0);
        else if (m_st == M_IDLE) r = d;
        else r = 1'b1;
        return {g, y, c, d, r};
    endfunction

    // apply inputs at negedge, clock once, return at the next negedge
    task automatic cyc(input logic [N-1:0] s, input logic a);
        S   = s;
        ACK = a;
        @(posedge CLK);
        if (model_on) model_step(s, a);
        @(negedge CLK);
    endtask

    task automatic chk(input string nm, input logic [4:0] exp);
        logic [4:0] got;
        got = {G, Y, C, D, R};
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: GYCDR got %b expected %b", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        #1;
        chk("rst_async", 5'b00111);
        @(negedge CLK);
        chk("rst_held", 5'b00111);
        RST_N = 1'b1;
        model_reset();
    endtask

    task automatic add(input logic [N-1:0] s, input logic a,
                       input logic [4:0] e, input int n);
        vec_t v;
        v.s   = s;
        v.ack = a;
        v.exp = e;
        for (int i = 0; i < n; i++) tbl.push_back(v);
    endtask

    initial begin
        logic [N-1:0] v;
        int           len;
        int           n;
        logic         a;

        vectors     = 0;
        miscompares = 0;
        model_on    = 1'b0;
        model_reset();
        RST_N = 1'b0;
        S     = '1;
        ACK   = 1'b0;

        // reset held with all sensors on, then debounce after release
        repeat (3) @(negedge CLK);
        chk("reset_hold", 5'b00111);
        RST_N = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 1'b0);
            chk("deb_wait", 5'b00111);
        end
        cyc(3'b111, 1'b0);
        chk("deb_set", 5'b11000);
        cyc(3'b111, 1'b0);
        chk("alarm_enter", 5'b11001);
        do_reset();

        // glitch reject, decode sweep, blink, hold, ack release
        add(3'b001, 1'b0, 5'b00111, 3);
        add(3'b000, 1'b0, 5'b00111, 1);
        add(3'b001, 1'b0, 5'b00111, 3);
        add(3'b001, 1'b0, 5'b10100, 1);
        add(3'b011, 1'b0, 5'b10100, 3);
        add(3'b011, 1'b0, 5'b11111, 1);
        add(3'b111, 1'b0, 5'b11111, 3);
        add(3'b111, 1'b0, 5'b11000, 1);
        add(3'b111, 1'b0, 5'b11001, 8);
        add(3'b111, 1'b0, 5'b11000, 8);
        add(3'b111, 1'b0, 5'b11001, 3);
        add(3'b001, 1'b0, 5'b11001, 3);
        add(3'b001, 1'b0, 5'b10101, 1);
        add(3'b001, 1'b0, 5'b10101, 3);
        add(3'b001, 1'b1, 5'b10100, 1);
        add(3'b001, 1'b0, 5'b10100, 2);
        foreach (tbl[i]) begin
            cyc(tbl[i].s, tbl[i].ack);
            chk($sformatf("tbl%0d", i), tbl[i].exp);
        end

        // acknowledge in ALARM, steady lamp, clear to IDLE
        repeat (3) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        chk("ack_deb", 5'b11000);
        cyc(3'b111, 1'b0);
        chk("ack_alarm", 5'b11001);
        cyc(3'b111, 1'b1);
        chk("acked", 5'b11001);
        for (int i = 0; i < 10; i++) begin
            cyc(3'b111, 1'b0);
            chk("acked_steady", 5'b11001);
        end
        repeat (3) cyc(3'b100, 1'b0);
        cyc(3'b100, 1'b0);
        chk("acked_deb", 5'b10101);
        cyc(3'b100, 1'b0);
        chk("acked_clear", 5'b10100);

        // simultaneous clear and acknowledge
        repeat (4) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        chk("sim_alarm", 5'b11001);
        repeat (3) cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        chk("sim_deb", 5'b10101);
        cyc(3'b001, 1'b1);
        chk("clr_ack", 5'b10100);
        cyc(3'b001, 1'b0);
        chk("clr_ack_stay", 5'b10100);

        // HOLD re-arm has priority over ACK, then mid-HOLD reset
        repeat (4) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        repeat (3) cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        chk("hold", 5'b10101);
        repeat (3) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        chk("hold_deb", 5'b11001);
        cyc(3'b111, 1'b1);
        chk("hold_prio", 5'b11001);
        repeat (7) cyc(3'b111, 1'b0);
        cyc(3'b111, 1'b0);
        chk("realarm_low", 5'b11000);
        repeat (3) cyc(3'b001, 1'b0);
        cyc(3'b001, 1'b0);
        chk("drop_low", 5'b10100);
        cyc(3'b001, 1'b0);
        chk("hold2", 5'b10101);
        S = 3'b111;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(3'b111, 1'b0);
            chk("post_rst_deb", 5'b00111);
        end
        cyc(3'b111, 1'b0);
        chk("post_rst_set", 5'b11000);
        cyc(3'b111, 1'b0);
        chk("post_rst_alarm", 5'b11001);

        // randomized run against the model
        do_reset();
        model_on = 1'b1;
        n = 0;
        while (n < 3000) begin
            if ($urandom_range(0, 1) == 0) v = '1;
            else v = N'($urandom);
            len = $urandom_range(1, 12);
            for (int j = 0; j < len && n < 3000; j++) begin
                a = ($urandom_range(0, 7) == 0);
                cyc(v, a);
                chk("rand", model_exp());
                n++;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sensor_alarm_ctrl.md
# sensor_alarm_ctrl

Parametrised successor to the three-sensor indicator decoder. Monitors N raw sensor lines, debounces each one, and decodes the debounced vector into status indicators G, Y, C and D. It also drives an alarm output R through a latching, acknowledgeable state machine with a programmable blink divider. It sits between the raw sensor pins and the panel lamp drivers.

## Interface
Parameters:
- N, 3: number of sensor channels; N ≥ 2.
- DEBOUNCE, 4: consecutive cycles an input must differ from its debounced value before that value updates; ≥ 1.
- WARN_TH, 2: active-channel count at which Y asserts; 1 ≤ WARN_TH ≤ N.
- BLINK_DIV, 8: R half-period in ALARM, in CLK cycles; ≥ 1.

Ports:
- CLK  input  1  system clock; all state changes on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- S  input  N  raw sensor lines, active high, asynchronous to nothing (already in the CLK domain).
- ACK  input  1  operator acknowledge, level sampled on each CLK edge.
- G  output  1  any channel active.
- Y  output  1  warning: active count ≥ WARN_TH.
- C  output  1  not all channels active.
- D  output  1  even parity of the debounced vector (1 when an even number of channels is active).
- R  output  1  alarm lamp.

## Operation
- Debounce, per channel i: register deb[i] and counter cnt[i] with width clog2(DEBOUNCE+1).
  - If S[i] == deb[i]: cnt[i] ← 0.
  - Else if cnt[i] == DEBOUNCE−1: deb[i] ← S[i] and cnt[i] ← 0.
  - Else: cnt[i] ← cnt[i]+1.
  - Any return to agreement clears the count, so glitches shorter than DEBOUNCE cycles never propagate.
- Decode, combinational from the deb registers only:
  - k = popcount(deb), width clog2(N+1).
  - G = (k ≥ 1), Y = (k ≥ WARN_TH), C = (k < N), D = ~^deb.
- all_on = ~C.
- Alarm FSM, 2-bit state:
  - IDLE: R = D. all_on → ALARM.
  - ALARM: R = phase.
    - ACK & all_on → ACKED.
    - ~all_on & ~ACK → HOLD.
    - ~all_on & ACK → IDLE (simultaneous clear and acknowledge).
  - HOLD, latched unacknowledged alarm: R = 1. all_on → ALARM (takes priority over ACK). Otherwise ACK → IDLE.
  - ACKED: R = 1. ~all_on → IDLE. ACK is ignored.
- Blink divider: counter bcnt with width clog2(BLINK_DIV) (minimum 1) and register phase.
  - On any transition into ALARM: bcnt ← 0, phase ← 1.
  - While in ALARM: if bcnt == BLINK_DIV−1, then bcnt ← 0 and phase ← ~phase; else bcnt ← bcnt+1.
  - Held (not counting) in all other states.
- Reset (RST_N low, immediate, independent of CLK):
  - deb = 0, cnt = 0, state = IDLE, bcnt = 0, phase = 0.
  - Outputs during and after reset: G=0, Y=0, C=1, D=1, R=1.
- Reset asserted mid-ALARM/HOLD/ACKED discards the latch. After release the FSM returns to ALARM only if all_on is re-established through debounce.

## Timing
- A raw change stable from edge t updates deb at edge t+DEBOUNCE−1. G/Y/C/D change in the same cycle as deb (combinational decode of registers, glitch-free).
- FSM latency is one edge after deb: the edge where all_on is first seen high moves the state to ALARM. R = 1 (phase) from that cycle.
- In ALARM, R holds each level for exactly BLINK_DIV cycles; the first high period is also BLINK_DIV cycles.
- ACK needs only a one-cycle pulse and is sampled only in ALARM and HOLD.
- R in IDLE tracks D with zero added latency.

## Test plan
- Reset: hold RST_N=0 with S=3'b111 → G=0, Y=0, C=1, D=1, R=1. After release, deb stays 0 for 3 edges and reaches 3'b111 on the 4th edge (N=3, DEBOUNCE=4).
- Glitch reject: S[0] pulses high for 3 cycles, then low → deb, G and R unchanged. A 4-cycle pulse → G=1, Y=0, D=0, R=0.
- Decode sweep: deb=001 → G=1, Y=0, C=1, D=0. deb=011 → Y=1, D=1, R=1. deb=111 → C=0 and state ALARM on the next edge.
- Blink: all_on with BLINK_DIV=8 → R high for 8 cycles, low for 8, high for 8, and so on. Drop one sensor with no ACK → HOLD, R=1 steady. ACK pulse → IDLE, R=D.
- Acknowledge: in ALARM, ACK=1 for 1 cycle → ACKED, R=1 steady. Clear a sensor → IDLE next edge. In ALARM, drop all_on and ACK on the same edge → IDLE directly.
- Mid-operation reset: pulse RST_N low during HOLD → immediately IDLE with R=1 and deb=0. Re-apply S=111 → ALARM only after debounce completes.
